// File: rtl/wb_unit_pkg.sv
// Shared CPU definitions for the writeback stage: FSM state and branch-type
// encodings, the EX/WB control bundle and the taken-branch rule.
package wb_unit_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } wb_state_e;

  localparam logic BTYPE_ZERO = 1'b0;
  localparam logic BTYPE_NEG  = 1'b1;

  localparam int CNT_W = 4;
  localparam int DW    = 32;

  typedef struct packed {
    logic regwrt;
    logic branch;
    logic btype;
    logic jump;
    logic memtoreg;
    logic neg;
    logic zero;
  } wb_ctrl_t;

  // A jump always redirects; a branch tests the flag chosen by btype.
  function automatic logic is_taken(input wb_ctrl_t c);
    return c.jump | (c.branch & ((c.btype == BTYPE_NEG) ? c.neg : c.zero));
  endfunction

endpackage

// File: rtl/regfile64.sv
// 2^AW x DW register file: one synchronous write port with clear, NRD
// combinational read ports that forward the in-flight write.
module regfile64 #(
  parameter int AW  = 6,
  parameter int DW  = 32,
  parameter int NRD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [NRD-1:0][AW-1:0]   raddr,
  output logic [NRD-1:0][DW-1:0]   rdata
);

  localparam int NREGS = 1 << AW;

  logic [DW-1:0] mem [NREGS];

  // Register 0 is an ordinary register here; nothing is hardwired.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rdata[p] = (we && (raddr[p] == waddr)) ? wdata : mem[raddr[p]];
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: commits or squashes the EX/WB instruction, writes the
// register file, issues one-cycle fetch redirects and counts retirements.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3,
  parameter int REG_AW      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_ctrl_regwrt,
  input  logic              in_ctrl_branch,
  input  logic              in_ctrl_btype,
  input  logic              in_ctrl_jump,
  input  logic              in_ctrl_memtoreg,
  input  logic              in_ctrl_neg,
  input  logic              in_ctrl_zero,
  input  logic [31:0]       in_memdata,
  input  logic [31:0]       in_aluresult,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [31:0]       in_target,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [31:0]       rs_data,
  output logic [31:0]       rt_data,
  output logic              out_pc_sel,
  output logic [31:0]       out_pc_target,
  output logic              out_flush,
  output logic [31:0]       out_retired
);

  wb_ctrl_t             ctrl;
  wb_state_e            state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 commit, taken, redirect, rf_we;
  logic [DW-1:0]        wdata;
  logic [1:0][DW-1:0]   rd_bus;

  assign ctrl = '{regwrt:   in_ctrl_regwrt,
                  branch:   in_ctrl_branch,
                  btype:    in_ctrl_btype,
                  jump:     in_ctrl_jump,
                  memtoreg: in_ctrl_memtoreg,
                  neg:      in_ctrl_neg,
                  zero:     in_ctrl_zero};

  // Reset outranks everything, so nothing commits on a reset edge.
  assign commit   = !rst && (state == RUN);
  assign taken    = is_taken(ctrl);
  assign redirect = commit & taken;
  assign rf_we    = commit & ctrl.regwrt;
  assign wdata    = ctrl.memtoreg ? in_memdata : in_aluresult;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: begin
        if (taken) begin
          state_nx = FLUSH;
          cnt_nx   = CNT_W'(FLUSH_DEPTH);
        end
      end
      FLUSH: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      cnt           <= '0;
      out_pc_sel    <= 1'b0;
      out_pc_target <= '0;
      out_retired   <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      out_pc_sel    <= redirect;
      out_pc_target <= redirect ? in_target : 32'h0;
      if (commit) out_retired <= out_retired + 32'd1;
    end
  end

  assign out_flush = (state == FLUSH);

  regfile64 #(
    .AW  (REG_AW),
    .DW  (DW),
    .NRD (2)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (in_rd),
    .wdata (wdata),
    .raddr ({rt_addr, rs_addr}),
    .rdata (rd_bus)
  );

  assign rs_data = rd_bus[0];
  assign rt_data = rd_bus[1];

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus randomized traffic
// against a slot-counting reference model of commit/squash behaviour.
`timescale 1ns/10ps
module tb_wb_unit;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrt, branch, btype, jump, memtoreg, neg, zero;
  logic [31:0] memdata, aluresult, target;
  logic [5:0]  rd, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, pc_target, retired;
  logic        pc_sel, flush;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register array, retire count, squash slots remaining.
  logic [31:0] m_rf [64];
  logic [31:0] m_ret;
  int          m_left;
  logic        m_sel;
  logic [31:0] m_tgt;

  always #5 clk = ~clk;

  wb_unit #(.FLUSH_DEPTH(DEPTH), .REG_AW(6)) dut (
    .clk(clk), .rst(rst),
    .in_ctrl_regwrt(regwrt), .in_ctrl_branch(branch), .in_ctrl_btype(btype),
    .in_ctrl_jump(jump), .in_ctrl_memtoreg(memtoreg), .in_ctrl_neg(neg),
    .in_ctrl_zero(zero), .in_memdata(memdata), .in_aluresult(aluresult),
    .in_rd(rd), .in_target(target), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .out_pc_sel(pc_sel),
    .out_pc_target(pc_target), .out_flush(flush), .out_retired(retired)
  );

  task automatic idle();
    regwrt = 0; branch = 0; btype = 0; jump = 0; memtoreg = 0; neg = 0; zero = 0;
    memdata = 0; aluresult = 0; target = 0; rd = 0;
  endtask

  task automatic model_edge();
    bit tk;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_rf[i] = 0;
      m_ret = 0; m_left = 0; m_sel = 0; m_tgt = 0;
    end else if (m_left > 0) begin
      m_left--; m_sel = 0; m_tgt = 0;
    end else begin
      if (regwrt) m_rf[rd] = memtoreg ? memdata : aluresult;
      m_ret = m_ret + 1;
      tk = jump || (branch && (btype ? neg : zero));
      m_sel = tk;
      m_tgt = tk ? target : 32'h0;
      if (tk) m_left = DEPTH;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle(); rst = 1; regwrt = 1; rd = 9; aluresult = 32'h1234; jump = 1; target = 32'h99;
    tick();
    @(negedge clk);
    idle();
    tick();
    n_checks++;
    if (pc_sel !== 1'b0 || pc_target !== 32'h0 || flush !== 1'b0 || retired !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: sel=%b tgt=%h flush=%b ret=%0d, want 0/0/0/0",
               pc_sel, pc_target, flush, retired);
    end
    for (int i = 0; i < 32; i++) begin
      rs_addr = 6'(i); rt_addr = 6'(63 - i);
      #0.1;
      n_checks++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_regs[%0d/%0d]: got %h/%h, want 0", i, 63 - i, rs_data, rt_data);
      end
    end
    rst = 0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    idle(); regwrt = 1; aluresult = 32'h0000_00A5; memdata = 32'hFFFF_0000; rd = 7; rs_addr = 7;
    #1;
    n_checks++;
    if (rs_data !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL bypass_rs7: got %h, want 000000a5", rs_data);
    end
    tick();
    idle();
    #0.1;
    n_checks++;
    if (rs_data !== 32'h0000_00A5 || retired !== 32'd1) begin
      n_fail++; $display("FAIL write_read: rs=%h ret=%0d, want 000000a5/1", rs_data, retired);
    end
  endtask

  task automatic test_memtoreg();
    @(negedge clk);
    idle(); regwrt = 1; memtoreg = 1; memdata = 32'hDEAD_BEEF; aluresult = 32'h1; rd = 12;
    tick();
    idle(); rt_addr = 12;
    #0.1;
    n_checks++;
    if (rt_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL memtoreg_r12: got %h, want deadbeef", rt_data);
    end
  endtask

  task automatic test_taken_branch();
    logic [31:0] base;
    int          fl_cycles;
    base = m_ret;
    @(negedge clk);
    idle(); branch = 1; btype = 0; zero = 1; target = 32'h40;
    tick();
    n_checks++;
    if (pc_sel !== 1'b1 || pc_target !== 32'h40 || flush !== 1'b1) begin
      n_fail++; $display("FAIL branch_redirect: sel=%b tgt=%h flush=%b, want 1/40/1", pc_sel, pc_target, flush);
    end
    fl_cycles = 1;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      idle(); regwrt = 1; rd = 3; aluresult = 32'h7777_0000 + k;
      tick();
      if (flush === 1'b1) fl_cycles++;
      n_checks++;
      if (pc_sel !== 1'b0) begin
        n_fail++; $display("FAIL branch_sel_one_cycle[%0d]: sel=%b, want 0", k, pc_sel);
      end
    end
    idle(); rs_addr = 3;
    #0.1;
    n_checks++;
    if (fl_cycles != DEPTH || rs_data !== 32'h0 || retired !== base + 1) begin
      n_fail++;
      $display("FAIL branch_squash: flush_cycles=%0d r3=%h ret=%0d, want %0d/0/%0d",
               fl_cycles, rs_data, retired, DEPTH, base + 1);
    end
  endtask

  task automatic test_untaken_and_squashed_jump();
    int fl_cycles;
    @(negedge clk);
    idle(); branch = 1; btype = 1; neg = 0; zero = 1; target = 32'h80;
    tick();
    n_checks++;
    if (pc_sel !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL untaken_branch: sel=%b flush=%b, want 0/0", pc_sel, flush);
    end
    @(negedge clk);
    idle(); jump = 1; target = 32'h200;
    tick();
    fl_cycles = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (flush === 1'b1) fl_cycles++;
      @(negedge clk);
      idle();
      if (k == 1) begin jump = 1; target = 32'h300; end
      tick();
      if (k < DEPTH) begin
        n_checks++;
        if (pc_sel !== 1'b0) begin
          n_fail++; $display("FAIL squashed_jump_sel[%0d]: sel=%b, want 0", k, pc_sel);
        end
      end
    end
    n_checks++;
    if (fl_cycles != DEPTH) begin
      n_fail++; $display("FAIL squashed_jump_flush_len: got %0d, want %0d", fl_cycles, DEPTH);
    end
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk);
    idle(); regwrt = 1; rd = 20; aluresult = 32'h5555_AAAA;
    tick();
    @(negedge clk);
    idle(); jump = 1; target = 32'h500;
    tick();
    @(negedge clk);
    idle(); rst = 1; regwrt = 1; rd = 21; aluresult = 32'h1;
    tick();
    n_checks++;
    if (flush !== 1'b0 || retired !== 32'h0 || pc_sel !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flush: flush=%b ret=%0d sel=%b, want 0/0/0", flush, retired, pc_sel);
    end
    idle(); rst = 0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 6'(2 * i); rt_addr = 6'(2 * i + 1);
      #0.1;
      n_checks++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
        n_fail++; $display("FAIL rst_mid_flush_regs[%0d]: got %h/%h, want 0", 2 * i, rs_data, rt_data);
      end
    end
    @(negedge clk);
    idle(); regwrt = 1; rd = 5; aluresult = 32'hCAFE_0005;
    tick();
    idle(); rs_addr = 5;
    #0.1;
    n_checks++;
    if (retired !== 32'd1 || rs_data !== 32'hCAFE_0005) begin
      n_fail++; $display("FAIL post_reset_commit: ret=%0d r5=%h, want 1/cafe0005", retired, rs_data);
    end
  endtask

  task automatic test_jump_link();
    @(negedge clk);
    idle(); jump = 1; regwrt = 1; rd = 63; aluresult = 32'h104; target = 32'h1000;
    tick();
    idle(); rt_addr = 63;
    #0.1;
    n_checks++;
    if (pc_sel !== 1'b1 || pc_target !== 32'h1000 || rt_data !== 32'h104) begin
      n_fail++; $display("FAIL jump_link: sel=%b tgt=%h r63=%h, want 1/1000/104", pc_sel, pc_target, rt_data);
    end
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk); idle(); tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] wd, exp_rs, exp_rt;
    bit          wr;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 49) == 0);
      regwrt    = $urandom_range(0, 1);
      branch    = ($urandom_range(0, 3) == 0);
      btype     = $urandom_range(0, 1);
      jump      = ($urandom_range(0, 9) == 0);
      memtoreg  = $urandom_range(0, 1);
      neg       = $urandom_range(0, 1);
      zero      = $urandom_range(0, 1);
      memdata   = $urandom;
      aluresult = $urandom;
      target    = $urandom;
      rd        = 6'($urandom_range(0, 7));
      rs_addr   = ($urandom_range(0, 1) == 1) ? rd : 6'($urandom_range(0, 7));
      rt_addr   = 6'($urandom_range(0, 63));
      wr = !rst && (m_left == 0) && regwrt;
      wd = memtoreg ? memdata : aluresult;
      exp_rs = (wr && rs_addr == rd) ? wd : m_rf[rs_addr];
      exp_rt = (wr && rt_addr == rd) ? wd : m_rf[rt_addr];
      #1;
      n_checks++;
      if (rs_data !== exp_rs || rt_data !== exp_rt) begin
        n_fail++;
        $display("FAIL rand_read[%0d]: rs=%h rt=%h, want %h/%h", n, rs_data, rt_data, exp_rs, exp_rt);
      end
      tick();
      n_checks++;
      if (pc_sel !== m_sel || pc_target !== m_tgt || flush !== (m_left > 0) || retired !== m_ret) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: sel=%b tgt=%h flush=%b ret=%0d, want %b/%h/%b/%0d",
                 n, pc_sel, pc_target, flush, retired, m_sel, m_tgt, (m_left > 0), m_ret);
      end
    end
    rst = 0;
  endtask

  initial begin
    idle(); rst = 1; rs_addr = 0; rt_addr = 0;
    for (int i = 0; i < 64; i++) m_rf[i] = 0;
    m_ret = 0; m_left = 0; m_sel = 0; m_tgt = 0;
    test_reset();
    test_write_read();
    test_memtoreg();
    test_taken_branch();
    test_untaken_and_squashed_jump();
    test_reset_mid_flush();
    test_jump_link();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
